cpu_trace_buffer: RTL and testbench

Synthesizable retire/trace capture block for the pipelined RISC-V core.
- Records per-cycle pipeline snapshots (pc, inst, alu_out, hazard flags) into a parametrised circular buffer.
- Capture runs in wrap, stop-on-full or PC-trigger mode, with a cycle timeout that ends the capture.
- Sits beside CPU; sampled contents are read back by the bench or a debug port after the `done` flag is set.

---
 rtl/cpu_trace_buffer_pkg.sv | 10 +
 rtl/cpu_trace_buffer_if.sv | 12 +
 rtl/cpu_trace_buffer_ram.sv | 19 +
 rtl/cpu_trace_buffer.sv | 106 ++++++++++
 tb/tb_cpu_trace_buffer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_trace_buffer_pkg.sv
// cpu_trace_buffer_pkg: capture-state encoding, mode codes and entry geometry for the trace buffer
package cpu_trace_buffer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_POST, ST_DONE} trace_state_e;
  localparam logic [1:0] MODE_STOP = 2'd1;
  localparam logic [1:0] MODE_TRIG = 2'd2;
  localparam int FLAGS_W = 3;
  function automatic int entry_w(input int xlen);
    return FLAGS_W + 2 * xlen + 32;
  endfunction
endpackage

// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if: per-cycle pipeline snapshot bus from the core (master) to the trace buffer (slave)
// signals: cap_valid, cap_pc[XLEN], cap_inst[32], cap_alu[XLEN], cap_flags[3] = {stall, rs1_hazard, rs2_hazard}
interface cpu_trace_buffer_if #(parameter int XLEN = 32);
  import cpu_trace_buffer_pkg::*;
  logic cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [31:0] cap_inst;
  logic [XLEN-1:0] cap_alu;
  logic [FLAGS_W-1:0] cap_flags;
  modport master (output cap_valid, cap_pc, cap_inst, cap_alu, cap_flags);
  modport slave (input cap_valid, cap_pc, cap_inst, cap_alu, cap_flags);
endinterface

// File: rtl/cpu_trace_buffer_ram.sv
// cpu_trace_buffer_ram: DEPTH x W simple dual-port RAM, one write port, registered read (read-before-write)
// ports: clk, we/waddr/wdata write side, raddr in, rdata out one cycle later
module cpu_trace_buffer_ram #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular capture of pipeline snapshots in wrap, stop-on-full or PC-trigger mode with timeout
// ports: clk, reset (sync, active high), arm, mode, trig_pc, cap (snapshot bus, slave),
//        rd_addr -> rd_data/rd_valid (oldest-relative, registered), count, busy, done, triggered, stall_count
// build option: TRACE_STALL_CNT_EN enables the saturating stall counter, otherwise stall_count is 0
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  parameter int POST_TRIG = 8,
  parameter int TIMEOUT = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic arm,
  input  logic [1:0] mode,
  input  logic [XLEN-1:0] trig_pc,
  cpu_trace_buffer_if.slave cap,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [3+2*XLEN+32-1:0] rd_data,
  output logic rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic busy,
  output logic done,
  output logic triggered,
  output logic [XLEN-1:0] stall_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_w(XLEN);
  localparam int PW = $clog2(POST_TRIG + 1);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [PW-1:0] POST_LAST = POST_TRIG[PW-1:0];
  localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT - 1);
  trace_state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_phys;
  logic [AW:0] count_q, count_d;
  logic [PW-1:0] post_q, post_d;
  logic [CW-1:0] cyc_q;
  logic busy_q, done_q, triggered_q, rd_valid_q, wr_en, hit, timeout;
  logic [EW-1:0] ram_q;
  always_comb begin
    wr_en = !arm && busy_q && cap.cap_valid;
    hit = wr_en && state_q == ST_ARMED && mode == MODE_TRIG && cap.cap_pc == trig_pc;
    timeout = TIMEOUT != 0 && cyc_q == CYC_LAST;
    count_d = wr_en && count_q != FULL ? count_q + 1'b1 : count_q;
    post_d = hit ? PW'(1) : post_q + PW'(wr_en && state_q == ST_POST);
    // the trigger entry is post entry 1, so POST_TRIG == 1 finishes on the trigger itself
    state_d = arm ? ST_ARMED
            : !busy_q ? state_q
            : timeout ? ST_DONE
            : state_q == ST_ARMED && mode == MODE_STOP && count_d == FULL ? ST_DONE
            : (hit || state_q == ST_POST) && post_d == POST_LAST ? ST_DONE
            : hit ? ST_POST
            : state_q;
    // count == DEPTH wraps to 0 in the low bits, which is exactly the oldest slot
    rd_phys = wr_ptr_q - count_q[AW-1:0] + rd_addr;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wr_ptr_q <= '0;
      count_q <= '0;
      post_q <= '0;
      cyc_q <= '0;
      triggered_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q <= state_d == ST_ARMED || state_d == ST_POST;
      done_q <= state_d == ST_DONE;
      wr_ptr_q <= arm ? '0 : wr_ptr_q + AW'(wr_en);
      count_q <= arm ? '0 : count_d;
      post_q <= arm ? '0 : post_d;
      cyc_q <= arm ? '0 : cyc_q + CW'(busy_q);
      triggered_q <= !arm && (triggered_q || hit);
      rd_valid_q <= {1'b0, rd_addr} < count_q;
    end
  end
  cpu_trace_buffer_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk(clk),
    .we(wr_en),
    .waddr(wr_ptr_q),
    .wdata({cap.cap_flags, cap.cap_pc, cap.cap_inst, cap.cap_alu}),
    .raddr(rd_phys),
    .rdata(ram_q)
  );
  assign rd_data = rd_valid_q ? ram_q : '0;
  assign rd_valid = rd_valid_q;
  assign count = count_q;
  assign busy = busy_q;
  assign done = done_q;
  assign triggered = triggered_q;
`ifdef TRACE_STALL_CNT_EN
  logic [XLEN-1:0] stall_q;
  always_ff @(posedge clk) begin
    if (reset || arm) stall_q <= '0;
    else if (busy_q && cap.cap_valid && cap.cap_flags[2] && stall_q != '1) stall_q <= stall_q + 1'b1;
  end
  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: randomized and directed capture scenarios checked against a queue-based trace model
module tb_cpu_trace_buffer;
  import cpu_trace_buffer_pkg::*;
  localparam int XLEN = 32, DEPTH = 16, POST_TRIG = 8, TIMEOUT = 100;
  localparam int EW = 3 + 2 * XLEN + 32;
  logic clk = 1'b0, reset = 1'b1, arm = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [XLEN-1:0] trig_pc = '0;
  logic [3:0] rd_addr = '0;
  logic [EW-1:0] rd_data, rd_data5;
  logic rd_valid, busy, done, triggered, rd_valid5, busy5, done5, triggered5;
  logic [4:0] count, count5;
  logic [XLEN-1:0] stall_count, stall_count5;
  int total = 0, bad = 0;
  logic [EW-1:0] q[$];
  bit m_cap, m_done, m_trig, e_rv;
  int m_post, m_cyc, m_stall;
  logic [EW-1:0] e_rd;
  cpu_trace_buffer_if #(.XLEN(XLEN)) cap_if();
  always #5 clk = ~clk;
  cpu_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .arm(arm), .mode(mode), .trig_pc(trig_pc), .cap(cap_if),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .busy(busy),
    .done(done), .triggered(triggered), .stall_count(stall_count)
  );
  cpu_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TIMEOUT(5)) dut5 (
    .clk(clk), .reset(reset), .arm(arm), .mode(mode), .trig_pc(trig_pc), .cap(cap_if),
    .rd_addr(rd_addr), .rd_data(rd_data5), .rd_valid(rd_valid5), .count(count5), .busy(busy5),
    .done(done5), .triggered(triggered5), .stall_count(stall_count5)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_step(input logic [EW-1:0] ent);
    e_rv = int'(rd_addr) < q.size();
    e_rd = e_rv ? q[rd_addr] : '0;
    if (reset) begin
      q.delete();
      {m_cap, m_done, m_trig, e_rv} = '0;
      {m_post, m_cyc, m_stall} = '0;
      e_rd = '0;
    end else if (arm) begin
      q.delete();
      m_cap = 1;
      {m_done, m_trig} = '0;
      {m_post, m_cyc, m_stall} = '0;
    end else if (m_cap) begin
      m_cyc++;
      if (cap_if.cap_valid) begin
        q.push_back(ent);
        if (q.size() > DEPTH) void'(q.pop_front());
        if (cap_if.cap_flags[2]) m_stall++;
        if (m_trig) m_post++;
        else if (mode == 2'd2 && cap_if.cap_pc == trig_pc) begin
          m_trig = 1;
          m_post = 1;
        end
      end
      if (m_cyc == TIMEOUT || (!m_trig && mode == 2'd1 && q.size() == DEPTH) || (m_trig && m_post == POST_TRIG)) begin
        m_cap = 0;
        m_done = 1;
      end
    end
  endtask
  task automatic step(input bit a, input bit v, input logic [XLEN-1:0] pc, input logic [2:0] fl, input int ra = -1);
    logic [EW-1:0] ent;
    arm = a;
    cap_if.cap_valid = v;
    cap_if.cap_pc = pc;
    cap_if.cap_inst = $urandom;
    cap_if.cap_alu = $urandom;
    cap_if.cap_flags = fl;
    rd_addr = ra < 0 ? 4'($urandom) : 4'(ra);
    ent = {fl, pc, cap_if.cap_inst, cap_if.cap_alu};
    @(posedge clk);
    model_step(ent);
    #1;
    chk("count", 128'(count), 128'(q.size()));
    chk("busy", 128'(busy), 128'(m_cap));
    chk("done", 128'(done), 128'(m_done));
    chk("triggered", 128'(triggered), 128'(m_trig));
    chk("rd_valid", 128'(rd_valid), 128'(e_rv));
    chk("rd_data", 128'(rd_data), 128'(e_rd));
`ifdef TRACE_STALL_CNT_EN
    chk("stall_count", 128'(stall_count), 128'(m_stall));
`else
    chk("stall_count", 128'(stall_count), 128'(0));
`endif
  endtask
  function automatic logic [XLEN-1:0] pc_of(input logic [EW-1:0] d);
    return d[EW-4 -: XLEN];
  endfunction
  initial begin
    int k;
    logic [11:0] stall_mask;
    cap_if.cap_valid = 1'b0;
    cap_if.cap_pc = '0;
    cap_if.cap_inst = '0;
    cap_if.cap_alu = '0;
    cap_if.cap_flags = '0;
    step(0, 1, 32'h40, 3'd7);
    step(1, 1, 32'h44, 3'd7);
    chk("reset_count", 128'(count), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    reset = 1'b0;
    mode = 2'd0;
    step(1, 1, 32'h999, 3'd0);
    for (int i = 0; i < 20; i++) step(0, 1, 32'(i * 4), 3'($urandom));
    chk("wrap_count", 128'(count), 128'(16));
    step(0, 0, 32'h0, 3'd0, 0);
    chk("wrap_oldest_pc", 128'(pc_of(rd_data)), 128'(32'h10));
    step(0, 0, 32'h0, 3'd0, 15);
    chk("wrap_newest_pc", 128'(pc_of(rd_data)), 128'(32'h4C));
    k = 22;
    while (!done && k < 150) begin
      step(0, 1'($urandom), 32'($urandom), 3'($urandom));
      k++;
    end
    chk("wrap_timeout_cycle", 128'(k), 128'(100));
    mode = 2'd1;
    step(1, 0, 32'h0, 3'd0);
    for (int i = 0; i < 16; i++) step(0, 1, 32'(i * 4), 3'($urandom));
    chk("stop_done", 128'(done), 128'(1));
    step(0, 1, 32'h40, 3'd0);
    chk("stop_no_17th", 128'(count), 128'(16));
    step(0, 0, 32'h0, 3'd0, 0);
    chk("stop_first_pc", 128'(pc_of(rd_data)), 128'(0));
    mode = 2'd2;
    trig_pc = 32'h20;
    step(1, 0, 32'h0, 3'd0);
    k = 0;
    while (!done && k < 40) begin
      step(0, 1, 32'(k * 4), 3'($urandom));
      k++;
    end
    chk("trig_seen", 128'(triggered), 128'(1));
    chk("trig_writes", 128'(k), 128'(16));
    step(0, 0, 32'h0, 3'd0, 15);
    chk("trig_last_pc", 128'(pc_of(rd_data)), 128'(32'h3C));
    step(1, 1, 32'h20, 3'd0);
    chk("arm_cycle_not_stored", 128'(count), 128'(0));
    chk("arm_cycle_no_trig", 128'(triggered), 128'(0));
    step(0, 1, 32'h20, 3'd0);
    step(0, 1, 32'h24, 3'd0);
    chk("post_triggered", 128'(triggered), 128'(1));
    step(1, 1, 32'h55, 3'd0);
    chk("rearm_count", 128'(count), 128'(0));
    chk("rearm_trig", 128'(triggered), 128'(0));
    chk("rearm_busy", 128'(busy), 128'(1));
    step(0, 1, 32'h100, 3'd0);
    step(0, 0, 32'h0, 3'd0, 0);
    chk("rearm_first_pc", 128'(pc_of(rd_data)), 128'(32'h100));
    mode = 2'd0;
    step(1, 0, 32'h0, 3'd0, 0);
    for (int j = 1; j <= 5; j++) begin
      step(0, 0, 32'h0, 3'd0, 0);
      chk("t5_done", 128'(done5), 128'(j == 5));
    end
    chk("t5_count", 128'(count5), 128'(0));
    chk("t5_rd_valid", 128'(rd_valid5), 128'(0));
    chk("t5_rd_data", 128'(rd_data5), 128'(0));
    stall_mask = 12'b1010_0110_1101;
    step(1, 0, 32'h0, 3'd0);
    for (int i = 0; i < 12; i++) step(0, 1, 32'(i * 4), {stall_mask[i], 2'($urandom)});
`ifdef TRACE_STALL_CNT_EN
    chk("stall_total", 128'(stall_count), 128'(7));
`else
    chk("stall_total", 128'(stall_count), 128'(0));
`endif
    reset = 1'b1;
    step(0, 1, 32'h8, 3'd4);
    reset = 1'b0;
    chk("midreset_count", 128'(count), 128'(0));
    chk("midreset_busy", 128'(busy), 128'(0));
    chk("midreset_stall", 128'(stall_count), 128'(0));
    for (int i = 0; i < 800; i++) begin
      reset = $urandom_range(0, 149) == 0;
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0 ? trig_pc : 32'($urandom_range(0, 63) * 4), 3'($urandom));
    end
    reset = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
